// File: rtl/dual_counter_snapshot_pkg.sv
// Shared constants and types for the dual-lane counter snapshot block.
package dual_counter_snapshot_pkg;

  localparam int LANE_WIDTH = 24;
  localparam int NUM_LANES  = 2;
  localparam logic [LANE_WIDTH-1:0] SAT_VALUE = 24'hFFFFFF;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Rollover count saturates at 3; anything >= 2 already forces saturation.
  function automatic logic [1:0] wrap_inc(input logic [1:0] wraps, input logic pulse);
    if (pulse && (wraps != 2'd3)) begin
      return 2'(wraps + 2'd1);
    end
    return wraps;
  endfunction

endpackage

// File: rtl/dual_counter_snapshot_lane_delta.sv
// One lane: previous snapshot, rollover counter for the open window,
// and the delta/saturation result for the most recent capture.
module lane_delta
  import dual_counter_snapshot_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANE_WIDTH-1:0] count_i,
  input  logic                  overflow_i,
  input  logic                  prime_i,
  input  logic                  capture_i,
  output logic [LANE_WIDTH-1:0] delta_o,
  output logic                  sat_o
);

  logic [LANE_WIDTH-1:0] prev_q, prev_d;
  logic [LANE_WIDTH-1:0] cur_q, cur_d;
  logic [LANE_WIDTH-1:0] base_q, base_d;
  logic [1:0]            wraps_q, wraps_d;
  logic [1:0]            cur_wraps_q, cur_wraps_d;
  logic [1:0]            wraps_inc;
  logic [LANE_WIDTH-1:0] raw_delta;
  logic                  sat;

  // A rollover in the capture cycle still belongs to the window being closed.
  always_comb begin
    wraps_inc   = wrap_inc(wraps_q, overflow_i);
    wraps_d     = wraps_inc;
    prev_d      = prev_q;
    cur_d       = cur_q;
    base_d      = base_q;
    cur_wraps_d = cur_wraps_q;
    if (prime_i || capture_i) begin
      prev_d  = count_i;
      wraps_d = 2'd0;
    end
    if (capture_i) begin
      cur_d       = count_i;
      base_d      = prev_q;
      cur_wraps_d = wraps_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= '0;
      cur_q       <= '0;
      base_q      <= '0;
      wraps_q     <= '0;
      cur_wraps_q <= '0;
    end else begin
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      base_q      <= base_d;
      wraps_q     <= wraps_d;
      cur_wraps_q <= cur_wraps_d;
    end
  end

  // Zero rollovers with cur < base means the upstream counter was reset.
  always_comb begin
    raw_delta = cur_q - base_q;
    sat = (cur_wraps_q >= 2'd2) ||
          ((cur_wraps_q == 2'd1) && (cur_q >= base_q)) ||
          ((cur_wraps_q == 2'd0) && (cur_q < base_q));
    delta_o = sat ? SAT_VALUE : raw_delta;
    sat_o   = sat;
  end

endmodule

// File: rtl/dual_counter_snapshot.sv
// Gate timer, PRIME/RUN sequencing and valid/ready result register for
// periodic per-lane deltas of a dual 24-bit counter.
module dual_counter_snapshot
  import dual_counter_snapshot_pkg::*;
#(
  parameter int GATE_CYCLES = 1000000,
  parameter int TIMER_BITS  = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [47:0] count,
  input  logic [1:0]  overflow,
  output logic [47:0] dat_o,
  output logic [1:0]  sat_o,
  output logic        overrun_o,
  output logic        valid_o,
  input  logic        ready_i
);

  logic [TIMER_BITS-1:0] timer_q, timer_d;
  logic                  gate_tick;
  state_e                state_q;
  logic                  prime, capture;
  logic                  calc_q, calc_d;
  logic [47:0]           dat_q, dat_d;
  logic [1:0]            sat_q, sat_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic [47:0]           delta_all;
  logic [1:0]            sat_all;
  logic                  accept;

  always_comb begin
    gate_tick = en && (timer_q == TIMER_BITS'(GATE_CYCLES - 1));
    timer_d   = timer_q + 1'b1;
    if (!en || gate_tick) begin
      timer_d = '0;
    end
    prime   = gate_tick && (state_q == PRIME);
    capture = gate_tick && (state_q == RUN);
    calc_d  = capture;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PRIME;
    end else if (!en) begin
      state_q <= PRIME;
    end else if (gate_tick) begin
      state_q <= RUN;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_delta u_lane (
      .clk        (clk),
      .rst        (rst),
      .count_i    (count[i*LANE_WIDTH +: LANE_WIDTH]),
      .overflow_i (overflow[i]),
      .prime_i    (prime),
      .capture_i  (capture),
      .delta_o    (delta_all[i*LANE_WIDTH +: LANE_WIDTH]),
      .sat_o      (sat_all[i])
    );
  end

  // A fresh result beats a same-cycle acceptance; overwriting an unaccepted one is an overrun.
  always_comb begin
    accept    = valid_q && ready_i;
    dat_d     = dat_q;
    sat_d     = sat_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (calc_q) begin
      dat_d   = delta_all;
      sat_d   = sat_all;
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
    if (calc_q && valid_q && !ready_i) begin
      overrun_d = 1'b1;
    end else if (accept) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q   <= '0;
      calc_q    <= 1'b0;
      dat_q     <= '0;
      sat_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      calc_q    <= calc_d;
      dat_q     <= dat_d;
      sat_q     <= sat_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign dat_o     = dat_q;
  assign sat_o     = sat_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_dual_counter_snapshot.sv
// Self-checking bench: gate-level arithmetic model compared every cycle,
// plus literal expectations on accepted results for directed scenarios.
module tb_dual_counter_snapshot;

  localparam int GATE = 16;

  logic        clk;
  logic        rst;
  logic        en;
  logic [47:0] count;
  logic [1:0]  overflow;
  logic [47:0] dat_o;
  logic [1:0]  sat_o;
  logic        overrun_o;
  logic        valid_o;
  logic        ready_i;

  logic [23:0] cnt0, cnt1;
  logic [1:0]  ov;

  int checks = 0;
  int failures = 0;

  // Model state
  bit          m_live = 0;
  int          m_tpos;
  bit          m_primed;
  logic [23:0] m_prev [2];
  int          m_wraps [2];
  bit          m_pend;
  logic [47:0] m_pdat;
  logic [1:0]  m_psat;
  bit          exp_valid;
  logic [47:0] exp_dat;
  logic [1:0]  exp_sat;
  bit          exp_ovr;

  logic [49:0] acc_q [$];

  assign count    = {cnt1, cnt0};
  assign overflow = ov;

  dual_counter_snapshot #(
    .GATE_CYCLES (GATE),
    .TIMER_BITS  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .count     (count),
    .overflow  (overflow),
    .dat_o     (dat_o),
    .sat_o     (sat_o),
    .overrun_o (overrun_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: elapsed count over the gate in true integers; anything outside one lane range saturates.
  task automatic modelStep();
    bit          accept, load, tick;
    logic [23:0] cur;
    longint      elapsed;
    if (rst) begin
      m_live = 1; m_tpos = 0; m_primed = 0; m_pend = 0;
      exp_valid = 0; exp_dat = '0; exp_sat = '0; exp_ovr = 0;
      for (int i = 0; i < 2; i++) begin m_prev[i] = '0; m_wraps[i] = 0; end
      return;
    end
    accept = exp_valid && ready_i;
    load   = m_pend;
    if (load && exp_valid && !ready_i) exp_ovr = 1;
    else if (accept) exp_ovr = 0;
    if (load) begin
      exp_valid = 1; exp_dat = m_pdat; exp_sat = m_psat;
    end else if (accept) begin
      exp_valid = 0;
    end
    m_pend = 0;
    for (int i = 0; i < 2; i++) begin
      if (overflow[i] && m_wraps[i] < 3) m_wraps[i]++;
    end
    tick = en && (m_tpos == GATE - 1);
    if (tick) begin
      for (int i = 0; i < 2; i++) begin
        cur = count[i*24 +: 24];
        elapsed = longint'(cur) - longint'(m_prev[i]) + longint'(m_wraps[i]) * (64'sd1 << 24);
        if (elapsed < 0 || elapsed >= (64'sd1 << 24)) begin
          m_psat[i] = 1'b1;
          m_pdat[i*24 +: 24] = 24'hFFFFFF;
        end else begin
          m_psat[i] = 1'b0;
          m_pdat[i*24 +: 24] = elapsed[23:0];
        end
        m_prev[i]  = cur;
        m_wraps[i] = 0;
      end
      if (m_primed) m_pend = 1;
      m_primed = 1;
    end
    if (!en) begin
      m_primed = 0;
      m_tpos   = 0;
    end else begin
      m_tpos = tick ? 0 : m_tpos + 1;
    end
  endtask

  always @(posedge clk) begin
    modelStep();
    #1;
    if (m_live) begin
      checkOutput("valid_o", 64'(valid_o), 64'(exp_valid));
      checkOutput("overrun_o", 64'(overrun_o), 64'(exp_ovr));
      if (exp_valid) begin
        checkOutput("dat_o", 64'(dat_o), 64'(exp_dat));
        checkOutput("sat_o", 64'(sat_o), 64'(exp_sat));
      end
      if (valid_o && ready_i) acc_q.push_back({sat_o, dat_o});
    end
  end

  function automatic logic [49:0] entry_at(input int idx);
    if (idx < acc_q.size()) return acc_q[idx];
    return '1;
  endfunction

  task automatic stepCounts(input int inc0, input int inc1, input bit pulse0);
    logic [23:0] old0, old1;
    old0 = cnt0;
    old1 = cnt1;
    cnt0 = cnt0 + inc0[23:0];
    cnt1 = cnt1 + inc1[23:0];
    ov[0] = (cnt0 < old0) || pulse0;
    ov[1] = (cnt1 < old1);
  endtask

  task automatic applyStimulus(input int cycles, input int inc0, input int inc1, input int pulse_at);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      stepCounts(inc0, inc1, k == pulse_at);
    end
  endtask

  // Leaves the bench at the negedge of a gate_tick cycle, with that cycle's count driven.
  task automatic syncToTick(input int inc1);
    for (int k = 0; k < 4 * GATE; k++) begin
      @(negedge clk);
      stepCounts(1, inc1, 1'b0);
      if (en && m_tpos == GATE - 1) return;
    end
    checkOutput("sync_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    rst = 1; en = 0; ready_i = 1; cnt0 = '0; cnt1 = '0; ov = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", 64'(valid_o), 64'd0);
    checkOutput("reset_dat", 64'(dat_o), 64'd0);
    checkOutput("reset_sat_ovr", 64'({sat_o, overrun_o}), 64'd0);

    // Lane0 +1/cycle from 0, lane1 static 5: first gate primes, then delta 16 / 0.
    @(negedge clk);
    rst = 0; en = 1; cnt0 = 24'd0; cnt1 = 24'd5; ov = '0;
    acc_q.delete();
    applyStimulus(72, 1, 0, -1);
    checkOutput("s1_count", 64'(acc_q.size()), 64'd3);
    checkOutput("s1_first", 64'(entry_at(0)), 64'({2'b00, 24'd0, 24'd16}));
    checkOutput("s1_last", 64'(entry_at(2)), 64'({2'b00, 24'd0, 24'd16}));

    // Rollover: prev = FFFFF8, one overflow, cur = 000008.
    syncToTick(0);
    cnt0 = 24'hFFFFF8; ov = '0;
    acc_q.delete();
    applyStimulus(16, 1, 0, -1);
    applyStimulus(6, 1, 0, -1);
    checkOutput("s2_count", 64'(acc_q.size()), 64'd2);
    checkOutput("s2_rollover", 64'(entry_at(1)), 64'({2'b00, 24'd0, 24'd16}));

    // One pulse with cur = prev+4, then a pulse in the capture cycle, then a clean gate.
    syncToTick(0);
    acc_q.delete();
    applyStimulus(4, 1, 0, -1);
    applyStimulus(12, 0, 0, 5);
    applyStimulus(15, 1, 0, -1);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(20, 1, 0, -1);
    checkOutput("s3_count", 64'(acc_q.size()), 64'd4);
    checkOutput("s3_pulse_small", 64'(entry_at(1)), 64'({2'b01, 24'd0, 24'hFFFFFF}));
    checkOutput("s3_pulse_capture", 64'(entry_at(2)), 64'({2'b01, 24'd0, 24'hFFFFFF}));
    checkOutput("s3_clean_after", 64'(entry_at(3)), 64'({2'b00, 24'd0, 24'd16}));

    // Stalled consumer across two gates -> overwrite and overrun, cleared by transfer.
    syncToTick(0);
    ready_i = 0;
    applyStimulus(20, 1, 0, -1);
    checkOutput("s4_valid_held", 64'(valid_o), 64'd1);
    checkOutput("s4_overrun", 64'(overrun_o), 64'd1);
    checkOutput("s4_dat", 64'({sat_o, dat_o}), 64'({2'b00, 24'd0, 24'd16}));
    ready_i = 1;
    @(posedge clk);
    #1;
    checkOutput("s4_valid_cleared", 64'(valid_o), 64'd0);
    checkOutput("s4_overrun_cleared", 64'(overrun_o), 64'd0);

    // en low for 3 cycles mid-gate: restart, PRIME gate, then one good result.
    syncToTick(3);
    applyStimulus(5, 1, 3, -1);
    en = 0;
    applyStimulus(3, 1, 3, -1);
    en = 1;
    acc_q.delete();
    applyStimulus(40, 1, 3, -1);
    checkOutput("s5_count", 64'(acc_q.size()), 64'd1);
    checkOutput("s5_after_prime", 64'(entry_at(0)), 64'({2'b00, 24'd48, 24'd16}));

    // Reset while valid and overrun are set.
    ready_i = 0;
    applyStimulus(40, 1, 3, -1);
    checkOutput("s6_pre_valid_ovr", 64'({valid_o, overrun_o}), 64'b11);
    rst = 1;
    @(posedge clk);
    #1;
    checkOutput("s6_rst_outputs", 64'({valid_o, overrun_o, sat_o}), 64'd0);
    checkOutput("s6_rst_dat", 64'(dat_o), 64'd0);
    @(negedge clk);
    rst = 0; ready_i = 1;
    acc_q.delete();
    applyStimulus(30, 1, 3, -1);
    checkOutput("s6_no_early_result", 64'(acc_q.size()), 64'd0);
    applyStimulus(8, 1, 3, -1);
    checkOutput("s6_first_after_reset", 64'(acc_q.size()), 64'd1);
    checkOutput("s6_result", 64'(entry_at(0)), 64'({2'b00, 24'd48, 24'd16}));

    applyStimulus(4, 1, 3, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
